// File: rtl/memory2_unit.sv
// Second memory stage: registers the memory1 pass, extracts and extends dcache load data and
// splits misaligned loads into two dcache beats when MISALIGN_EN is set.
module memory2_unit #(
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned ADDR_W      = 32,
  parameter int unsigned IDX_W       = 5,
  parameter bit          MISALIGN_EN = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              is_stall,
  input  logic              is_flush,
  input  logic              in_valid,
  input  logic              in_is_load,
  input  logic [ADDR_W-1:0] in_addr,
  input  logic [1:0]        in_size,
  input  logic              in_is_signed,
  input  logic              in_is_wr_rd,
  input  logic [IDX_W-1:0]  in_rd,
  input  logic [DATA_W-1:0] in_ex_out,
  input  logic [ADDR_W-1:0] in_pc,
  input  logic              dcache_ready,
  input  logic [DATA_W-1:0] rd_dcache_data,
  output logic              dcache_hi_req,
  output logic [ADDR_W-1:0] dcache_hi_addr,
  output logic              dcache_stall,
  output logic              fwd_valid,
  output logic              fwd_pending,
  output logic [IDX_W-1:0]  fwd_idx,
  output logic [DATA_W-1:0] fwd_data,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic              out_is_wr_rd,
  output logic [IDX_W-1:0]  out_rd,
  output logic [ADDR_W-1:0] out_pc,
  output logic              out_ale
);

  localparam int unsigned OFF_W  = $clog2(DATA_W / 8);
  localparam int unsigned BASE_W = ADDR_W - OFF_W;
  localparam logic [4:0]  BYTES  = 5'(DATA_W / 8);

  typedef enum logic [1:0] {StIdle, StWaitHi, StHiWait} state_e;

  state_e              r_state, w_state_d;
  logic                r_valid, r_is_load, r_is_signed, r_is_wr_rd;
  logic [ADDR_W-1:0]   r_addr, r_pc;
  logic [1:0]          r_size;
  logic [IDX_W-1:0]    r_rd;
  logic [DATA_W-1:0]   r_ex_out, r_lo_buf;

  logic                w_v, w_ld, w_misaligned, w_ale, w_done, w_hold;
  logic                w_hi_req, w_lo_latch, w_use_hi, w_dcache_stall;
  logic [OFF_W-1:0]    w_off;
  logic [4:0]          w_span;
  logic [BASE_W-1:0]   w_hi_base;
  logic [2*DATA_W-1:0] w_pair;
  logic [DATA_W-1:0]   w_word, w_word_ext, w_load_data, w_out_data;

  // The stage must not drop an in-flight load, so it also holds on its own dcache stall.
  assign w_hold = is_stall | w_dcache_stall;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid     <= 1'b0;
      r_is_load   <= 1'b0;
      r_addr      <= '0;
      r_size      <= '0;
      r_is_signed <= 1'b0;
      r_is_wr_rd  <= 1'b0;
      r_rd        <= '0;
      r_ex_out    <= '0;
      r_pc        <= '0;
    end else if (!w_hold) begin
      r_valid     <= in_valid;
      r_is_load   <= in_is_load;
      r_addr      <= in_addr;
      r_size      <= in_size;
      r_is_signed <= in_is_signed;
      r_is_wr_rd  <= in_is_wr_rd;
      r_rd        <= in_rd;
      r_ex_out    <= in_ex_out;
      r_pc        <= in_pc;
    end else if (is_flush) begin
      r_valid <= 1'b0;
    end
  end

  assign w_v          = r_valid & ~is_flush;
  assign w_ld         = w_v & r_is_load;
  assign w_off        = r_addr[OFF_W-1:0];
  assign w_span       = 5'(w_off) + (5'd1 << r_size);
  assign w_misaligned = w_span > BYTES;
  assign w_ale        = w_ld & w_misaligned & (MISALIGN_EN == 1'b0);

  always_comb begin
    w_state_d  = r_state;
    w_done     = 1'b0;
    w_hi_req   = 1'b0;
    w_lo_latch = 1'b0;
    w_use_hi   = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (w_ld && dcache_ready && !w_ale) begin
          if (w_misaligned) begin
            w_lo_latch = 1'b1;
            w_state_d  = StWaitHi;
          end else begin
            w_done = 1'b1;
          end
        end
      end
      StWaitHi: begin
        w_hi_req  = 1'b1;
        w_state_d = StHiWait;
      end
      StHiWait: begin
        w_use_hi = 1'b1;
        if (dcache_ready) begin
          w_done    = 1'b1;
          w_state_d = StIdle;
        end
      end
      default: w_state_d = StIdle;
    endcase
    if (!w_v) begin
      w_state_d  = StIdle;
      w_done     = 1'b0;
      w_hi_req   = 1'b0;
      w_lo_latch = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= StIdle;
      r_lo_buf <= '0;
    end else begin
      r_state <= w_state_d;
      if (w_lo_latch) begin
        r_lo_buf <= rd_dcache_data;
      end else if (is_flush) begin
        r_lo_buf <= '0;
      end
    end
  end

  assign w_hi_base      = r_addr[ADDR_W-1:OFF_W] + BASE_W'(1);
  assign dcache_hi_addr = {w_hi_base, {OFF_W{1'b0}}};
  assign dcache_hi_req  = w_hi_req;

  // Aligned loads see a zero upper half; the second beat supplies it for split loads.
  assign w_pair = w_use_hi ? {rd_dcache_data, r_lo_buf} : {{DATA_W{1'b0}}, rd_dcache_data};
  assign w_word = DATA_W'(w_pair >> {w_off, 3'b000});

  if (DATA_W == 32) begin : g_word32
    assign w_word_ext = w_word;
  end else begin : g_word64
    assign w_word_ext = {{(DATA_W-32){r_is_signed & w_word[31]}}, w_word[31:0]};
  end

  always_comb begin
    w_load_data = w_word;
    unique case (r_size)
      2'd0:    w_load_data = {{(DATA_W-8){r_is_signed & w_word[7]}}, w_word[7:0]};
      2'd1:    w_load_data = {{(DATA_W-16){r_is_signed & w_word[15]}}, w_word[15:0]};
      2'd2:    w_load_data = w_word_ext;
      default: w_load_data = w_word;
    endcase
  end

  assign w_dcache_stall = w_ld & ~w_done & ~w_ale;
  assign w_out_data     = r_is_load ? w_load_data : r_ex_out;

  assign dcache_stall = w_dcache_stall;
  assign out_valid    = w_v & (~r_is_load | w_done | w_ale);
  assign out_data     = w_out_data;
  assign out_is_wr_rd = r_is_wr_rd & ~w_ale;
  assign out_rd       = r_rd;
  assign out_pc       = r_pc;
  assign out_ale      = w_ale;
  assign fwd_valid    = w_v & r_is_wr_rd & (~r_is_load | w_done);
  assign fwd_pending  = w_v & r_is_wr_rd & r_is_load & ~w_done;
  assign fwd_idx      = r_rd;
  assign fwd_data     = w_out_data;

endmodule
